data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//  Data-memory responder for Olivia's MEM stage; the CPU's LDUR/STUR path is the initiator.
//  Accepts one doubleword read/write request over a valid/ready handshake.
//  Holds the request for LATENCY wait cycles, then returns a response over a second valid/ready handshake.
//  Backed by a synchronous doubleword array; one transaction in flight at a time.
// PARAMETERS
//  DEPTH_WORDS  256  number of 64-bit doublewords; power of two, >= 2
//  LATENCY      2    wait cycles between accept and response; 0..15
// PORTS
//  clk         in   1   clock; everything on posedge
//  rst         in   1   reset, synchronous, active-high
//  req_valid   in   1   initiator presents a request
//  req_ready   out  1   responder can accept a request
//  req_write   in   1   1 = STUR (write), 0 = LDUR (read)
//  req_addr    in   64  byte address
//  req_wdata   in   64  store data; ignored for reads
//  resp_valid  out  1   response present
//  resp_ready  in   1   initiator takes the response
//  resp_rdata  out  64  load data; 0 for writes and errors
//  resp_err    out  1   out-of-range access (misaligned too if DMEM_ALIGN_CHECK_EN is defined)
//  busy        out  1   state != IDLE
// BEHAVIOUR
//  Reset values:
//   - state IDLE; resp_valid = 0; resp_rdata = 0; resp_err = 0; busy = 0.
//   - req_ready = 0 while rst = 1, and 1 on the first cycle after rst deasserts.
//   - Memory contents are NOT cleared.
//  FSM: IDLE -> WAIT -> RESP -> IDLE.
//   - req_ready = 1 only in IDLE.
//   - Accept edge: req_valid & req_ready. Captures write, addr and wdata.
//     Loads wait counter = LATENCY. Next state is WAIT, or RESP if LATENCY = 0.
//   - WAIT: counter decrements each cycle. When counter = 1, next state is RESP.
//   - Entry into RESP (one edge):
//     - read: rdata <= mem[idx].
//     - write: mem[idx] <= wdata, and rdata <= 0.
//     - err is computed on this same edge.
//   - resp_valid is high exactly LATENCY+1 cycles after the accept edge.
//   - RESP: resp_valid, resp_rdata and resp_err stay stable until resp_ready = 1.
//     On that handshake edge: resp_valid <= 0, state IDLE, req_ready = 1 next cycle.
//   - resp_ready may already be high when resp_valid rises; handshake completes that cycle.
//   - Throughput: at most one transaction per LATENCY+2 cycles.
//  Address arithmetic:
//   - idx = req_addr[$clog2(DEPTH_WORDS)+2 : 3].
//   - Out of range when any of req_addr[63 : $clog2(DEPTH_WORDS)+3] is nonzero.
//     Then err = 1, rdata = 0, no write.
//   - Highest valid index DEPTH_WORDS-1. No wrap-around: addr DEPTH_WORDS*8 is an error, not index 0.
//  Other boundaries:
//   - Request inputs are ignored outside IDLE; the initiator must hold req_valid until accepted.
//   - rst in WAIT aborts the transaction; a pending write is NOT performed.
//   - rst in RESP drops the response; a write already committed on RESP entry stays.
//   - rst and req_valid in the same cycle: the request is not accepted.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN defined:
//   - req_addr[2:0] != 0 gives err = 1, rdata = 0, no write.
//   - Out of range and misaligned in the same access still gives a single err = 1.
//  DMEM_ALIGN_CHECK_EN undefined:
//   - req_addr[2:0] is ignored; the access truncates to the containing doubleword, err = 0.
// TESTING (LATENCY = 2, DEPTH_WORDS = 256)
//  1. Write addr 0x10, data 0xDEAD_BEEF_0123_4567, resp_ready = 1
//     -> resp_valid 3 cycles after accept, err 0, rdata 0.
//     Then read 0x10 -> rdata 0xDEAD_BEEF_0123_4567.
//  2. Read with resp_ready = 0 for 5 cycles
//     -> resp_valid/rdata stable; req_ready 0 throughout.
//     Raise resp_ready -> req_ready = 1 next cycle.
//  3. Write addr 0x800 (index 256)
//     -> err 1, rdata 0. Read 0x000 -> unchanged (no wrap). Read 0x7F8 -> err 0.
//  4. Write 0x14 = 0x55 with macro defined -> err 1, index 2 unchanged.
//     Same write without the macro -> err 0, index 2 = 0x55.
//  5. Accept write 0x20 = 0x1, assert rst one cycle later
//     -> resp_valid never rises, req_ready returns after rst, index 4 unchanged.
//  6. LATENCY = 0 build: back-to-back requests with resp_ready = 1
//     -> resp_valid 1 cycle after each accept, one transaction per 2 cycles.

Source files
------------

// File: rtl/data_memory_responder.sv
// Doubleword data-memory responder: one request in, fixed-latency response out, one transaction in flight.
// Optional misaligned-address error: define DMEM_ALIGN_CHECK_EN.
module data_memory_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
    localparam int unsigned HI_LSB = IDX_W + 3;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             bad_q, bad_d;
    logic [63:0]      wdata_q, wdata_d;
    logic             resp_valid_q, resp_valid_d;
    logic [63:0]      resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;
    logic             busy_q, busy_d;

    logic [63:0]      mem_q [DEPTH_WORDS];
    logic             accept_c;
    logic             misalign_c;
    logic             mem_we_c;

`ifdef DMEM_ALIGN_CHECK_EN
    assign misalign_c = |req_addr[2:0];
`else
    // Byte offset is dropped; the access lands on the containing doubleword.
    logic unused_addr_lsb;
    assign misalign_c      = 1'b0;
    assign unused_addr_lsb = ^req_addr[2:0];
`endif

    // Ready is gated by rst so a request presented during reset is never taken.
    assign req_ready = (state_q == S_IDLE) && !rst;
    assign accept_c  = req_valid && req_ready;

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;

    // Next-state, capture and response logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        idx_d        = idx_q;
        bad_d        = bad_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_we_c     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    write_d = req_write;
                    idx_d   = req_addr[HI_LSB-1:3];
                    bad_d   = (|req_addr[63:HI_LSB]) || misalign_c;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_W'(LATENCY);
                    state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // RESP entry uses the _d capture so the zero-latency path sees the live request.
        if ((state_d == S_RESP) && (state_q != S_RESP)) begin
            resp_valid_d = 1'b1;
            resp_err_d   = bad_d;
            resp_rdata_d = (write_d || bad_d) ? 64'd0 : mem_q[idx_d];
            mem_we_c     = write_d && !bad_d;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            write_q      <= 1'b0;
            idx_q        <= '0;
            bad_q        <= 1'b0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            idx_q        <= idx_d;
            bad_q        <= bad_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
        end
    end

    // Storage is never cleared; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && mem_we_c) begin
            mem_q[idx_d] <= wdata_d;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed + randomized bench for data_memory_responder (LATENCY=2 main instance, LATENCY=0 throughput instance).
module tb_data_memory_responder;
    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    logic        z_req_valid = 1'b0;
    logic        z_req_ready;
    logic        z_req_write = 1'b0;
    logic [63:0] z_req_addr = '0;
    logic [63:0] z_req_wdata = '0;
    logic        z_resp_valid;
    logic        z_resp_ready = 1'b0;
    logic [63:0] z_resp_rdata;
    logic        z_resp_err;
    logic        z_busy;

    int total = 0;
    int bad   = 0;

    logic [63:0] mdl [DEPTH];
    logic [63:0] zm  [4];

    always #5 clk = ~clk;

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy)
    );

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_dut_lat0 (
        .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_write(z_req_write), .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready), .resp_rdata(z_resp_rdata),
        .resp_err(z_resp_err), .busy(z_busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: byte address -> doubleword number; anything past the array is an error.
    task automatic ref_access(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                              output logic [63:0] rd, output logic err);
        logic [63:0] word;
        word = addr / 8;
        err  = (word >= 64'(DEPTH));
`ifdef DMEM_ALIGN_CHECK_EN
        if ((addr % 8) != 0) err = 1'b1;
`endif
        rd = 64'd0;
        if (!err) begin
            if (wr) mdl[int'(word)] = wd;
            else    rd = mdl[int'(word)];
        end
    endtask

    // Full transaction on the main instance; starts and ends on a negedge.
    task automatic do_txn(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                          input int hold, input logic early, output logic [63:0] got);
        logic [63:0] exp_rd;
        logic        exp_err;
        logic [63:0] rd0;
        logic        err0;
        int          n;
        ref_access(wr, addr, wd, exp_rd, exp_err);
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wd;
        resp_ready = early;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_idle", 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = ~wr;
        req_addr  = 64'($urandom);
        req_wdata = {$urandom, $urandom};
        n = 1;
        while (!resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", 64'(n), 64'(LAT + 1));
        check("rdata", resp_rdata, exp_rd);
        check("err", 64'(resp_err), 64'(exp_err));
        check("req_ready_in_resp", 64'(req_ready), 64'd0);
        check("busy_in_resp", 64'(busy), 64'd1);
        got  = resp_rdata;
        rd0  = resp_rdata;
        err0 = resp_err;
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", 64'(resp_valid), 64'd1);
                check("hold_rdata", resp_rdata, rd0);
                check("hold_err", 64'(resp_err), 64'(err0));
                check("hold_req_ready", 64'(req_ready), 64'd0);
            end
            resp_ready = 1'b1;
        end
        @(negedge clk);
        resp_ready = 1'b0;
        check("valid_drop", 64'(resp_valid), 64'd0);
        check("req_ready_back", 64'(req_ready), 64'd1);
        check("busy_clear", 64'(busy), 64'd0);
    endtask

    task automatic z_drive(input int k);
        z_req_write = (k < 4);
        z_req_addr  = 64'(k % 4) * 64'd8;
        z_req_wdata = zm[k % 4];
    endtask

    logic [63:0] got;
    logic [63:0] addr;
    int          zop;
    int          zlast;
    int          zcyc;
    logic        acc;

    initial begin
        // Reset with a request pending: nothing may be accepted.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h8;
        z_req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_req_ready", 64'(req_ready), 64'd0);
            check("rst_resp_valid", 64'(resp_valid), 64'd0);
            check("rst_rdata", resp_rdata, 64'd0);
            check("rst_err", 64'(resp_err), 64'd0);
            check("rst_busy", 64'(busy), 64'd0);
            check("rst_z_busy", 64'(z_busy), 64'd0);
        end
        rst = 1'b0;
        req_valid = 1'b0;
        z_req_valid = 1'b0;
        #1;
        check("post_rst_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);

        // Give every doubleword a known value.
        for (int i = 0; i < DEPTH; i++)
            do_txn(1'b1, 64'(i) * 64'd8, {$urandom, $urandom}, 0, 1'b1, got);

        // Store then load at 0x10.
        do_txn(1'b1, 64'h10, 64'hDEAD_BEEF_0123_4567, 0, 1'b1, got);
        check("t1_write_rdata", got, 64'd0);
        do_txn(1'b0, 64'h10, 64'd0, 0, 1'b1, got);
        check("t1_read_rdata", got, 64'hDEAD_BEEF_0123_4567);

        // Back-pressured response stays stable.
        do_txn(1'b0, 64'h10, 64'd0, 5, 1'b0, got);

        // Range boundary: no wrap to index 0.
        do_txn(1'b1, 64'h800, 64'h1234, 1, 1'b0, got);
        do_txn(1'b0, 64'h000, 64'd0, 0, 1'b1, got);
        do_txn(1'b0, 64'h7F8, 64'd0, 0, 1'b1, got);

        // Unaligned store; outcome depends on the align-check build.
        do_txn(1'b1, 64'h14, 64'h55, 0, 1'b1, got);
        do_txn(1'b0, 64'h10, 64'd0, 0, 1'b1, got);

        // Reset while waiting aborts the pending write.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h20;
        req_wdata = 64'h1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort_valid", 64'(resp_valid), 64'd0);
        check("abort_req_ready_rst", 64'(req_ready), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        #1;
        check("abort_req_ready", 64'(req_ready), 64'd1);
        repeat (4) begin
            @(negedge clk);
            check("abort_no_valid", 64'(resp_valid), 64'd0);
        end
        do_txn(1'b0, 64'h20, 64'd0, 0, 1'b1, got);

        // Reset during the response keeps a committed write.
        addr = {$urandom, $urandom};
        mdl[6] = addr;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h30;
        req_wdata = addr;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        zcyc = 0;
        while (!resp_valid && zcyc < 20) begin
            @(negedge clk);
            zcyc++;
        end
        check("resp_rst_valid_up", 64'(resp_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("resp_rst_dropped", 64'(resp_valid), 64'd0);
        rst = 1'b0;
        do_txn(1'b0, 64'h30, 64'd0, 0, 1'b1, got);

        // Randomized mix against the reference array.
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 4))
                0: addr = 64'($urandom_range(0, DEPTH - 1)) * 64'd8;
                1: addr = 64'($urandom_range(0, DEPTH * 8 - 1));
                2: addr = 64'h7F8;
                3: addr = 64'h800 + 64'($urandom_range(0, 7)) * 64'd8;
                default: addr = {$urandom, $urandom};
            endcase
            do_txn(1'($urandom_range(0, 1)), addr, {$urandom, $urandom},
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got);
        end

        // Zero-latency instance: back-to-back with resp_ready held high.
        for (int i = 0; i < 4; i++) zm[i] = {$urandom, $urandom};
        z_resp_ready = 1'b1;
        z_req_valid  = 1'b1;
        zop   = 0;
        zlast = -1;
        zcyc  = 0;
        z_drive(0);
        while (zop < 8 && zcyc < 40) begin
            acc = z_req_ready;
            @(posedge clk);
            zcyc++;
            @(negedge clk);
            if (acc) begin
                check("z_valid", 64'(z_resp_valid), 64'd1);
                check("z_err", 64'(z_resp_err), 64'd0);
                check("z_rdata", z_resp_rdata, (zop < 4) ? 64'd0 : zm[zop % 4]);
                if (zlast >= 0) check("z_interval", 64'(zcyc - zlast), 64'd2);
                zlast = zcyc;
                zop++;
                if (zop < 8) z_drive(zop);
                else z_req_valid = 1'b0;
            end
        end
        check("z_done", 64'(zop), 64'd8);
        z_req_valid = 1'b0;
        @(negedge clk);
        check("z_idle", 64'(z_busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
